// File: rtl/keycode_sched_pkg.sv
// Shared constants and event record for the keycode scheduler.
// Channel field is sized for the largest supported channel count.
package keycode_sched_pkg;
    localparam int KC_W       = 16;
    localparam int NCH_DEF    = 4;
    localparam int DEPTH_DEF  = 8;
    localparam int CHAN_W_MAX = 3;

    typedef struct packed {
        logic [CHAN_W_MAX-1:0] chan;
        logic [KC_W-1:0]       code;
    } evt_t;
endpackage

// File: rtl/keycode_evt_fifo.sv
// Show-ahead event FIFO with occupancy count.
// Storage is unreset; the head is only meaningful while not empty.
module keycode_evt_fifo #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/keycode_scheduler.sv
// Detects keycode changes per channel and queues them round-robin.
// Shadows track the last value enqueued, so changes coalesce until grant.
module keycode_scheduler
    import keycode_sched_pkg::*;
#(
    parameter int NCH   = NCH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [KC_W*NCH-1:0]     kc_in,
    input  logic                    enable,
    output logic                    evt_valid,
    input  logic                    evt_ready,
    output logic [$clog2(NCH)-1:0]  evt_chan,
    output logic [KC_W-1:0]         evt_code,
    output logic [$clog2(DEPTH):0]  fifo_level
);
    localparam int CW = $clog2(NCH);

    logic [KC_W-1:0] kc     [NCH];
    logic [KC_W-1:0] shadow [NCH];
    logic [NCH-1:0]  pending;
    logic [CW-1:0]   rr_ptr;
    logic [CW-1:0]   grant_chan;
    logic            found;
    logic            grant;
    logic            full;
    logic            empty;
    evt_t            push_evt;
    evt_t            head;
    logic            unused_head;

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            kc[i]      = kc_in[KC_W*i +: KC_W];
            pending[i] = enable && (kc[i] != shadow[i]);
        end
    end

    // Scan farthest-first so the closest pending channel to rr_ptr wins.
    always_comb begin : arb
        int idx;
        idx        = 0;
        found      = 1'b0;
        grant_chan = '0;
        for (int k = NCH-1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NCH)
                idx = idx - NCH;
            if (pending[idx]) begin
                found      = 1'b1;
                grant_chan = CW'(idx);
            end
        end
    end

    assign grant         = found && !full;
    assign push_evt.chan = CHAN_W_MAX'(grant_chan);
    assign push_evt.code = kc[grant_chan];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr <= '0;
            for (int i = 0; i < NCH; i++)
                shadow[i] <= '0;
        end else if (grant) begin
            shadow[grant_chan] <= kc[grant_chan];
            if (grant_chan == CW'(NCH-1))
                rr_ptr <= '0;
            else
                rr_ptr <= grant_chan + 1'b1;
        end
    end

    keycode_evt_fifo #(
        .WIDTH ($bits(evt_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (grant),
        .din     (push_evt),
        .pop     (evt_ready),
        .dout    (head),
        .full    (full),
        .empty   (empty),
        .level   (fifo_level)
    );

    assign evt_valid   = !empty;
    assign evt_chan    = evt_valid ? head.chan[CW-1:0] : '0;
    assign evt_code    = evt_valid ? head.code : '0;
    assign unused_head = ^head.chan;
endmodule

// File: tb/tb_keycode_scheduler.sv
// Directed bench for keycode_scheduler (NCH=4, DEPTH=8).
// Inputs change 1ns after a rising edge; outputs sampled there too.
module tb_keycode_scheduler;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [63:0] kc_in;
    logic        enable;
    logic        evt_valid;
    logic        evt_ready;
    logic [1:0]  evt_chan;
    logic [15:0] evt_code;
    logic [3:0]  fifo_level;
    logic [15:0] kc [4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign kc_in = {kc[3], kc[2], kc[1], kc[0]};

    keycode_scheduler #(
        .NCH   (4),
        .DEPTH (8)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .kc_in      (kc_in),
        .enable     (enable),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_chan   (evt_chan),
        .evt_code   (evt_code),
        .fifo_level (fifo_level)
    );

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic chk_head(input string tag,
                            input logic v,
                            input logic [1:0] ch,
                            input logic [15:0] cd,
                            input logic [3:0] lv);
        chk({tag, "_valid"}, 32'(evt_valid), 32'(v));
        chk({tag, "_chan"}, 32'(evt_chan), 32'(ch));
        chk({tag, "_code"}, 32'(evt_code), 32'(cd));
        chk({tag, "_level"}, 32'(fifo_level), 32'(lv));
    endtask

    initial begin
        reset_n   = 1'b0;
        enable    = 1'b1;
        evt_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            kc[i] = '0;
        #2;
        chk_head("rst", 1'b0, 2'd0, 16'h0, 4'd0);
        tick(2);
        chk_head("rst_hold", 1'b0, 2'd0, 16'h0, 4'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        chk("idle_level", 32'(fifo_level), 32'd0);

        // single change, one-cycle latency
        kc[2] = 16'h001A;
        tick();
        chk_head("ch2", 1'b1, 2'd2, 16'h001A, 4'd1);
        evt_ready = 1'b1;
        tick();
        chk_head("ch2_pop", 1'b0, 2'd0, 16'h0, 4'd0);
        evt_ready = 1'b0;

        // round-robin from rr_ptr=0
        reset_n = 1'b0;
        kc[2]   = '0;
        tick();
        @(negedge clk);
        reset_n   = 1'b1;
        kc[0]     = 16'h0004;
        kc[1]     = 16'h0016;
        kc[3]     = 16'h0007;
        evt_ready = 1'b1;
        tick();
        chk_head("rr0", 1'b1, 2'd0, 16'h0004, 4'd1);
        tick();
        chk_head("rr1", 1'b1, 2'd1, 16'h0016, 4'd1);
        tick();
        chk_head("rr3", 1'b1, 2'd3, 16'h0007, 4'd1);
        tick();
        chk_head("rr_done", 1'b0, 2'd0, 16'h0, 4'd0);
        tick();
        chk("ready_idle_level", 32'(fifo_level), 32'd0);

        // saturate with ch1 changes
        evt_ready = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            kc[1] = 16'(16'h0100 + k);
            tick();
            chk("fill_level", 32'(fifo_level),
                32'(k < 8 ? k : 8));
        end
        chk("fill_head", 32'(evt_code), 32'h0101);

        // ch2 bounces back while full
        kc[2] = 16'h0004;
        tick();
        chk("bounce_a", 32'(fifo_level), 32'd8);
        kc[2] = 16'h0000;
        tick();
        chk("bounce_b", 32'(fifo_level), 32'd8);

        evt_ready = 1'b1;
        tick();
        chk("pop1_level", 32'(fifo_level), 32'd7);
        chk("pop1_head", 32'(evt_code), 32'h0102);
        evt_ready = 1'b0;
        tick();
        chk("latest_level", 32'(fifo_level), 32'd8);
        tick();
        chk("hold_level", 32'(fifo_level), 32'd8);

        evt_ready = 1'b1;
        for (int k = 2; k <= 9; k++) begin
            chk("drain_chan", 32'(evt_chan), 32'd1);
            chk("drain_code", 32'(evt_code),
                32'(16'h0100 + k));
            tick();
        end
        chk("drained", 32'(fifo_level), 32'd0);
        tick();
        chk("no_ch2", 32'(fifo_level), 32'd0);

        // full + pop + new change: push deferred a cycle
        evt_ready = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            kc[1] = 16'(16'h0200 + k);
            tick();
        end
        chk("full2_level", 32'(fifo_level), 32'd8);
        kc[2]     = 16'h0033;
        evt_ready = 1'b1;
        tick();
        chk("popfull_level", 32'(fifo_level), 32'd7);
        chk("popfull_head", 32'(evt_code), 32'h0202);
        evt_ready = 1'b0;
        tick();
        chk("ch2_late_level", 32'(fifo_level), 32'd8);
        evt_ready = 1'b1;
        for (int k = 2; k <= 8; k++) begin
            chk("drain2_code", 32'(evt_code),
                32'(16'h0200 + k));
            tick();
        end
        chk_head("ch2_last", 1'b1, 2'd2, 16'h0033, 4'd1);
        tick();
        chk("drained2", 32'(fifo_level), 32'd0);

        // reset mid-operation
        evt_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            kc[1] = 16'(16'h0300 + k);
            tick();
        end
        chk("five_level", 32'(fifo_level), 32'd5);
        kc[0]   = '0;
        kc[1]   = '0;
        kc[2]   = '0;
        kc[3]   = 16'h0029;
        reset_n = 1'b0;
        #1;
        chk_head("rst_mid", 1'b0, 2'd0, 16'h0, 4'd0);
        tick(2);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        chk_head("ch3", 1'b1, 2'd3, 16'h0029, 4'd1);
        tick();
        chk("ch3_only", 32'(fifo_level), 32'd1);

        // enable low blocks grants, not pops
        enable = 1'b0;
        kc[0]  = 16'h0055;
        tick();
        chk("dis_level", 32'(fifo_level), 32'd1);
        evt_ready = 1'b1;
        tick();
        chk_head("dis_pop", 1'b0, 2'd0, 16'h0, 4'd0);
        evt_ready = 1'b0;
        enable    = 1'b1;
        tick();
        chk_head("en", 1'b1, 2'd0, 16'h0055, 4'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
